csa_mult_sequencer: RTL and testbench
=====================================

CSA_MULT_SEQUENCER -- requirements
Module: csa_mult_sequencer

Interface
REQ-001 Parameters: none; the operand width is fixed at 32 and the product width at 64.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block idle and able to accept operands.
REQ-006 a  input  32  unsigned multiplicand.
REQ-007 b  input  32  unsigned multiplier.
REQ-008 out_valid  output  1  product available.
REQ-009 out_ready  input  1  consumer accepts the product.
REQ-010 product  output  64  unsigned a*b.
REQ-011 busy  output  1  high in REDUCE, RESOLVE and DONE.

Function
REQ-012 Exactly one 64-bit carry_save_adder instance shall be time-shared for all partial-product reduction.
- Its behaviour: sum[63]=0; carry[0]=0; carry[63:1] = per-bit full-adder carry of bits 62:0.
- The only other adder shall be one 64-bit carry-propagate add used in RESOLVE.
REQ-013 The FSM shall have the states IDLE, REDUCE, RESOLVE and DONE, one-hot or binary.
REQ-014 IDLE behaviour:
- in_ready=1.
- On in_valid&in_ready: latch a and b; clear sum_acc, carry_acc and idx (5-bit); go to REDUCE.
REQ-015 REDUCE behaviour, per cycle:
- pp = b_lat[idx] ? ({32'b0,a_lat} << idx) : 64'b0.
- sum_acc, carry_acc <= CSA(sum_acc, carry_acc, pp).
- idx <= idx+1.
REQ-016 REDUCE shall run exactly 32 cycles (idx 0..31) regardless of operand values; on the edge processing idx=31 it goes to RESOLVE, and idx wraps to 0.
REQ-017 RESOLVE shall register product <= sum_acc + carry_acc (mod 2^64) and go to DONE in one cycle.
REQ-018 DONE behaviour:
- out_valid=1; product held stable.
- On out_valid&out_ready: go to IDLE.
- out_valid shall not drop without a handshake.
REQ-019 Latency: with acceptance on edge T0, out_valid shall be high from edge T33.
REQ-020 Throughput: with in_valid and out_ready held high, the block shall accept operands every 35 cycles.
REQ-021 in_ready shall be 0 in every state except IDLE; a and b shall be ignored while in_ready=0.
REQ-022 product shall retain its last value after the DONE handshake until the next RESOLVE.
REQ-023 Dropping bit-63 sum and carry shall never corrupt the result, because any 32x32 product fits in 64 bits; the bench shall check this at the maximum operands.

Reset
REQ-024 When reset=1 at a rising edge, the block shall:
- go to IDLE;
- set in_ready=1, out_valid=0, busy=0, product=0;
- clear sum_acc, carry_acc, idx, a_lat and b_lat.
REQ-025 Reset shall take priority over every handshake and state transition, including mid-REDUCE, mid-RESOLVE and in DONE with out_valid pending; the in-flight operation shall be discarded with no output.
REQ-026 The handshake shall not be sampled in the cycle in which reset is high.

Verification
REQ-027 a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1 -> product=0xFFFFFFFE00000001 with out_valid rising exactly 33 edges after acceptance.
REQ-028 Two cases:
- a=0, b=12345 -> product=0.
- a=0x80000000, b=2 -> product=0x0000000100000000.
- Both: REDUCE shall still last 32 cycles.
REQ-029 a=3, b=5 with out_ready held low for 10 cycles after out_valid -> product=15 stable and in_ready=0 throughout; after the handshake, in_ready=1 on the next cycle.
REQ-030 reset pulsed on the 10th REDUCE cycle of a=7, b=6 -> next cycle in_ready=1, out_valid=0, product=0; a following a=7, b=6 yields 42.
REQ-031 Back-to-back stream with in_valid=1 and out_ready=1 -> acceptances spaced 35 cycles apart.
REQ-032 1000 random unsigned pairs plus edge values (0, 1, 0xFFFFFFFF, 0x80000000) -> every product equals the 64-bit a*b; in_ready and out_valid shall never be high in the same cycle.

Source files
------------

// File: rtl/csa_mult_sequencer.sv
// Sequential 32x32 unsigned multiplier: one time-shared 64-bit carry-save adder reduces the
// partial products over 32 cycles, then a single carry-propagate add resolves the product.

module carry_save_adder (
  input  logic [63:0] x,
  input  logic [63:0] y,
  input  logic [63:0] z,
  output logic [63:0] sum,
  output logic [63:0] carry
);

  // Bit 63 of sum and the carry out of bit 63 are dropped; a 32x32 product never needs them.
  always_comb begin
    sum       = x ^ y ^ z;
    sum[63]   = 1'b0;
    carry     = {(x[62:0] & y[62:0]) | (x[62:0] & z[62:0]) | (y[62:0] & z[62:0]), 1'b0};
  end

endmodule

module csa_mult_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StReduce  = 2'd1;
  localparam logic [1:0] StResolve = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] sum_q, sum_d;
  logic [63:0] carry_q, carry_d;
  logic [4:0]  idx_q, idx_d;
  logic [63:0] product_q, product_d;

  logic [63:0] pp;
  logic [63:0] csa_sum;
  logic [63:0] csa_carry;

  always_comb begin
    pp = b_q[idx_q] ? ({32'b0, a_q} << idx_q) : 64'b0;
  end

  carry_save_adder u_csa (
    .x     (sum_q),
    .y     (carry_q),
    .z     (pp),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sum_d   = 64'b0;
          carry_d = 64'b0;
          idx_d   = 5'd0;
          state_d = StReduce;
        end
      end
      StReduce: begin
        // Fixed 32 iterations; idx wraps back to 0 on the last one.
        sum_d   = csa_sum;
        carry_d = csa_carry;
        idx_d   = idx_q + 5'd1;
        if (idx_q == 5'd31) begin
          state_d = StResolve;
        end
      end
      StResolve: begin
        product_d = sum_q + carry_q;
        state_d   = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= 32'b0;
      b_q       <= 32'b0;
      sum_q     <= 64'b0;
      carry_q   <= 64'b0;
      idx_q     <= 5'd0;
      product_q <= 64'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    product   = product_q;
  end

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Directed and random checks of csa_mult_sequencer: products, latency, handshake and reset.

module tb_csa_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic        busy;

  int checks;
  int errors;
  int excl_viol;

  csa_mult_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (in_ready && out_valid) excl_viol++;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          hold;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction; operands are corrupted after acceptance to show they are ignored.
  task automatic do_mult(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [63:0] exp, input int hold, input string name);
    int cnt;
    @(negedge clk);
    check({name, " in_ready idle"}, 64'(in_ready), 64'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~ta;
    b = ~tb_v;
    check({name, " busy"}, 64'(busy), 64'd1);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({name, " latency"}, 64'(cnt), 64'd33);
    check({name, " product"}, product, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " hold product"}, product, exp);
      check({name, " hold in_ready"}, 64'(in_ready), 64'd0);
      check({name, " hold out_valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({name, " post in_ready"}, 64'(in_ready), 64'd1);
    check({name, " post out_valid"}, 64'(out_valid), 64'd0);
    check({name, " post product"}, product, exp);
    out_ready = 1'b0;
  endtask

  vec_t vecs[10];
  logic [31:0] edges[4];
  int t[4];
  int n;
  int cyc;
  int seen;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    checks = 0;
    errors = 0;
    excl_viol = 0;
    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0};
    vecs[1] = '{32'h0000_0000, 32'd12345,     64'h0,                   0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 0};
    vecs[3] = '{32'd3,         32'd5,         64'd15,                  10};
    vecs[4] = '{32'd1,         32'd1,         64'd1,                   0};
    vecs[5] = '{32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0};
    vecs[7] = '{32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 0};
    vecs[8] = '{32'd1000,      32'd1000,      64'd1000000,             2};
    vecs[9] = '{32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, 0};
    edges[0] = 32'h0;
    edges[1] = 32'h1;
    edges[2] = 32'hFFFF_FFFF;
    edges[3] = 32'h8000_0000;

    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    repeat (3) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset product", product, 64'd0);
    in_valid = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_mult(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Reset on the 10th REDUCE cycle discards the operation.
    @(negedge clk);
    a = 32'd7;
    b = 32'd6;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreduce in_ready", 64'(in_ready), 64'd1);
    check("midreduce out_valid", 64'(out_valid), 64'd0);
    check("midreduce busy", 64'(busy), 64'd0);
    check("midreduce product", product, 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midreduce no output", 64'(seen), 64'd0);
    do_mult(32'd7, 32'd6, 64'd42, 0, "after reset");

    // Reset while a result is pending in DONE.
    @(negedge clk);
    a = 32'd9;
    b = 32'd9;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("done pending product", product, 64'd81);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("done reset out_valid", 64'(out_valid), 64'd0);
    check("done reset in_ready", 64'(in_ready), 64'd1);
    check("done reset product", product, 64'd0);

    // Back-to-back stream.
    @(negedge clk);
    a = 32'd11;
    b = 32'd13;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 300) begin
      if (in_ready) begin
        t[n] = cyc;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("stream acceptances", 64'(n), 64'd4);
    for (int i = 1; i < 4; i++) begin
      check($sformatf("stream spacing %0d", i), 64'(t[i] - t[i-1]), 64'd35);
    end
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("stream product", product, 64'd143);
    @(negedge clk);
    out_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        do_mult(edges[i], edges[j], 64'(edges[i]) * 64'(edges[j]), 0,
                $sformatf("edge %h*%h", edges[i], edges[j]));
      end
    end

    for (int k = 0; k < 1000; k++) begin
      ra = $urandom;
      rb = $urandom;
      do_mult(ra, rb, 64'(ra) * 64'(rb), 0, $sformatf("rand %h*%h", ra, rb));
    end

    check("in_ready/out_valid exclusive", 64'(excl_viol), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
